// File: rtl/conv_window_feeder.sv
// Streaming 3x3 window generator: two line buffers and a 3x3 shift window turn a
// raster pixel stream into nine parallel operands for the carry-save adder stage.
package packConv;
  localparam int NBITS = 8;
endpackage

module conv_window_feeder
  import packConv::*;
#(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [NBITS-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [NBITS-1:0] op0,
  output logic [NBITS-1:0] op1,
  output logic [NBITS-1:0] op2,
  output logic [NBITS-1:0] op3,
  output logic [NBITS-1:0] op4,
  output logic [NBITS-1:0] op5,
  output logic [NBITS-1:0] op6,
  output logic [NBITS-1:0] op7,
  output logic [NBITS-1:0] op8,
  output logic             out_last
);

  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
  localparam logic [COL_W-1:0] COL_ONE  = COL_W'(1);
  localparam logic [ROW_W-1:0] ROW_ONE  = ROW_W'(1);
  localparam logic [COL_W-1:0] COL_TWO  = COL_W'(2);
  localparam logic [ROW_W-1:0] ROW_TWO  = ROW_W'(2);

  logic [COL_W-1:0] r_col;
  logic [ROW_W-1:0] r_row;
  logic [NBITS-1:0] r_lb0 [IMG_W];
  logic [NBITS-1:0] r_lb1 [IMG_W];
  logic [NBITS-1:0] r_win [3][3];
  logic [NBITS-1:0] r_op  [9];
  logic             r_valid;
  logic             r_last;

  logic             w_accept;
  logic             w_emit;
  logic             w_col_wrap;
  logic             w_frame_end;
  logic [NBITS-1:0] w_new   [3];
  logic [NBITS-1:0] w_shift [3][3];

  assign in_ready    = !r_valid || out_ready;
  assign w_accept    = in_valid && in_ready && !clear;
  assign w_col_wrap  = (r_col == COL_LAST);
  assign w_frame_end = w_col_wrap && (r_row == ROW_LAST);
  assign w_emit      = w_accept && (r_row >= ROW_TWO) && (r_col >= COL_TWO);

  // New column is oldest row at the top: lb0 (row-2), lb1 (row-1), incoming pixel.
  assign w_new[0] = r_lb0[r_col];
  assign w_new[1] = r_lb1[r_col];
  assign w_new[2] = in_data;

  always_comb begin
    for (int r = 0; r < 3; r++) begin
      w_shift[r][0] = r_win[r][1];
      w_shift[r][1] = r_win[r][2];
      w_shift[r][2] = w_new[r];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_col <= '0;
      r_row <= '0;
    end else if (clear) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_accept) begin
      if (w_col_wrap) begin
        r_col <= '0;
        r_row <= (r_row == ROW_LAST) ? '0 : r_row + ROW_ONE;
      end else begin
        r_col <= r_col + COL_ONE;
      end
    end
  end

  // Line buffers carry no reset; position gating keeps stale words off the outputs.
  always_ff @(posedge clock) begin
    if (w_accept) begin
      r_lb0[r_col] <= r_lb1[r_col];
      r_lb1[r_col] <= in_data;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          r_win[r][c] <= '0;
        end
      end
    end else if (w_accept) begin
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          r_win[r][c] <= w_shift[r][c];
        end
      end
    end
  end

  // A completing pixel reloads the output register even while the old window drains.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      for (int k = 0; k < 9; k++) begin
        r_op[k] <= '0;
      end
    end else if (clear) begin
      r_valid <= 1'b0;
    end else if (w_emit) begin
      r_valid <= 1'b1;
      r_last  <= w_frame_end;
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          r_op[3*r + c] <= w_shift[r][c];
        end
      end
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign out_valid = r_valid;
  assign out_last  = r_last;
  assign op0 = r_op[0];
  assign op1 = r_op[1];
  assign op2 = r_op[2];
  assign op3 = r_op[3];
  assign op4 = r_op[4];
  assign op5 = r_op[5];
  assign op6 = r_op[6];
  assign op7 = r_op[7];
  assign op8 = r_op[8];

endmodule

// File: tb/tb_conv_window_feeder.sv
// Scoreboard bench for conv_window_feeder: a 4x4 instance for the directed frames
// and an 8x6 instance for the random-stall run, each with its own monitor.
module tb_conv_window_feeder;
  import packConv::*;

  localparam int AW = 4;
  localparam int AH = 4;
  localparam int BW = 8;
  localparam int BH = 6;

  typedef struct packed {
    logic [9*NBITS-1:0] ops;
    logic               last;
    logic [31:0]        sum;
  } win_t;

  logic clock = 1'b0;
  logic reset_n = 1'b0;

  logic             aClear = 1'b0, aInValid = 1'b0, aOutReady = 1'b1;
  logic [NBITS-1:0] aInData = '0;
  logic             aInReady, aOutValid, aLast;
  logic [NBITS-1:0] aOp [9];
  logic [9*NBITS-1:0] aOpsFlat;

  logic             bClear = 1'b0, bInValid = 1'b0, bOutReady = 1'b1;
  logic [NBITS-1:0] bInData = '0;
  logic             bInReady, bOutValid, bLast;
  logic [NBITS-1:0] bOp [9];
  logic [9*NBITS-1:0] bOpsFlat;

  int checks = 0;
  int fails = 0;
  int aGot = 0;
  int bGot = 0;
  int aRow = 0, aCol = 0, bRow = 0, bCol = 0;
  win_t aQ[$];
  win_t bQ[$];
  int aSumQ[$];
  logic [NBITS-1:0] aPix [AH][AW];
  logic [NBITS-1:0] bPix [BH][BW];

  assign aOpsFlat = {aOp[8], aOp[7], aOp[6], aOp[5], aOp[4], aOp[3], aOp[2], aOp[1], aOp[0]};
  assign bOpsFlat = {bOp[8], bOp[7], bOp[6], bOp[5], bOp[4], bOp[3], bOp[2], bOp[1], bOp[0]};

  conv_window_feeder #(.IMG_W(AW), .IMG_H(AH)) dutA (
    .clock(clock), .reset_n(reset_n), .clear(aClear),
    .in_valid(aInValid), .in_ready(aInReady), .in_data(aInData),
    .out_valid(aOutValid), .out_ready(aOutReady),
    .op0(aOp[0]), .op1(aOp[1]), .op2(aOp[2]), .op3(aOp[3]), .op4(aOp[4]),
    .op5(aOp[5]), .op6(aOp[6]), .op7(aOp[7]), .op8(aOp[8]),
    .out_last(aLast)
  );

  conv_window_feeder #(.IMG_W(BW), .IMG_H(BH)) dutB (
    .clock(clock), .reset_n(reset_n), .clear(bClear),
    .in_valid(bInValid), .in_ready(bInReady), .in_data(bInData),
    .out_valid(bOutValid), .out_ready(bOutReady),
    .op0(bOp[0]), .op1(bOp[1]), .op2(bOp[2]), .op3(bOp[3]), .op4(bOp[4]),
    .op5(bOp[5]), .op6(bOp[6]), .op7(bOp[7]), .op8(bOp[8]),
    .out_last(bLast)
  );

  initial forever #5 clock = ~clock;

  function automatic logic [31:0] sumOps(input logic [9*NBITS-1:0] o);
    logic [31:0] s;
    s = '0;
    for (int k = 0; k < 9; k++) s += 32'(o[k*NBITS +: NBITS]);
    return s;
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Reference model: keeps the whole frame and cuts windows straight from it.
  task automatic modelA(input logic [NBITS-1:0] d);
    win_t e;
    aPix[aRow][aCol] = d;
    if (aRow >= 2 && aCol >= 2) begin
      e.ops = '0;
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          e.ops[(3*r + c)*NBITS +: NBITS] = aPix[aRow-2+r][aCol-2+c];
      e.last = (aRow == AH-1 && aCol == AW-1);
      e.sum = (aSumQ.size() > 0) ? 32'(aSumQ.pop_front()) : 32'hFFFF_FFFF;
      aQ.push_back(e);
    end
    if (aCol == AW-1) begin
      aCol = 0;
      aRow = (aRow == AH-1) ? 0 : aRow + 1;
    end else aCol++;
  endtask

  task automatic modelB(input logic [NBITS-1:0] d);
    win_t e;
    bPix[bRow][bCol] = d;
    if (bRow >= 2 && bCol >= 2) begin
      e.ops = '0;
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          e.ops[(3*r + c)*NBITS +: NBITS] = bPix[bRow-2+r][bCol-2+c];
      e.last = (bRow == BH-1 && bCol == BW-1);
      e.sum = sumOps(e.ops);
      bQ.push_back(e);
    end
    if (bCol == BW-1) begin
      bCol = 0;
      bRow = (bRow == BH-1) ? 0 : bRow + 1;
    end else bCol++;
  endtask

  task automatic applyStimulusA(input logic v, input logic [NBITS-1:0] d, input logic rdy,
                                input logic clr, output logic hs, output logic rdyS,
                                output logic [9*NBITS-1:0] opsS);
    @(negedge clock);
    aInValid = v; aInData = d; aOutReady = rdy; aClear = clr;
    #1;
    rdyS = aInReady;
    opsS = aOpsFlat;
    hs = v && aInReady && !clr;
    if (clr) begin aRow = 0; aCol = 0; end
    if (hs) modelA(d);
  endtask

  task automatic applyStimulusB(input logic v, input logic [NBITS-1:0] d, input logic rdy,
                                output logic hs);
    @(negedge clock);
    bInValid = v; bInData = d; bOutReady = rdy;
    #1;
    hs = v && bInReady;
    if (hs) modelB(d);
  endtask

  task automatic sendA(input int d);
    logic hs, r;
    logic [9*NBITS-1:0] o;
    int n;
    hs = 1'b0; n = 0;
    while (!hs && n < 50) begin
      applyStimulusA(1'b1, NBITS'(d), 1'b1, 1'b0, hs, r, o);
      n++;
    end
    if (!hs) begin
      checks++; fails++;
      $display("[TB] FAIL A send timeout: pixel %0d not accepted, required acceptance", d);
    end
  endtask

  task automatic drainA(input string name, input int startGot, input int expN);
    logic hs, r;
    logic [9*NBITS-1:0] o;
    int n;
    n = 0;
    while ((aQ.size() > 0 || aOutValid) && n < 40) begin
      applyStimulusA(1'b0, '0, 1'b1, 1'b0, hs, r, o);
      n++;
    end
    checkOutput({name, " window count"}, 128'(aGot - startGot), 128'(expN));
    checkOutput({name, " queue empty"}, 128'(aQ.size()), 128'(0));
    aQ.delete();
    aSumQ.delete();
  endtask

  // Monitors pop and compare whenever a window is consumed.
  initial begin : monA
    win_t e;
    forever begin
      @(negedge clock); #2;
      if (reset_n && aOutValid && aOutReady) begin
        aGot++;
        if (aQ.size() == 0) begin
          checks++; fails++;
          $display("[TB] FAIL A unexpected window: got sum %0d, required no window", sumOps(aOpsFlat));
        end else begin
          e = aQ.pop_front();
          checkOutput("A ops", 128'(aOpsFlat), 128'(e.ops));
          checkOutput("A last", 128'(aLast), 128'(e.last));
          checkOutput("A sum", 128'(sumOps(aOpsFlat)), 128'(e.sum));
        end
      end
    end
  end

  initial begin : monB
    win_t e;
    forever begin
      @(negedge clock); #2;
      if (reset_n && bOutValid && bOutReady) begin
        bGot++;
        if (bQ.size() == 0) begin
          checks++; fails++;
          $display("[TB] FAIL B unexpected window: got sum %0d, required no window", sumOps(bOpsFlat));
        end else begin
          e = bQ.pop_front();
          checkOutput("B ops", 128'(bOpsFlat), 128'(e.ops));
          checkOutput("B last", 128'(bLast), 128'(e.last));
          checkOutput("B sum", 128'(sumOps(bOpsFlat)), 128'(e.sum));
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    logic hs, r;
    logic [9*NBITS-1:0] o, snap;
    int start, n, bSent;

    repeat (2) @(negedge clock);
    #1;
    checkOutput("reset A out_valid", 128'(aOutValid), 128'(0));
    checkOutput("reset A out_last", 128'(aLast), 128'(0));
    checkOutput("reset A ops", 128'(aOpsFlat), 128'(0));
    checkOutput("reset A in_ready", 128'(aInReady), 128'(1));
    checkOutput("reset B out_valid", 128'(bOutValid), 128'(0));
    reset_n = 1'b1;

    $display("[TB] ramp frame");
    start = aGot;
    aSumQ = '{54, 63, 90, 99};
    for (int p = 1; p <= 16; p++) sendA(p);
    drainA("ramp", start, 4);

    $display("[TB] backpressure");
    start = aGot;
    aSumQ = '{54, 63, 90, 99};
    for (int p = 1; p <= 12; p++) sendA(p);
    snap = '0;
    for (int i = 0; i < 3; i++) begin
      applyStimulusA(1'b1, NBITS'(13), 1'b0, 1'b0, hs, r, o);
      checkOutput("stall in_ready", 128'(r), 128'(0));
      checkOutput("stall out_valid", 128'(aOutValid), 128'(1));
      if (i == 0) snap = o;
      else checkOutput("stall ops stable", 128'(o), 128'(snap));
    end
    for (int p = 13; p <= 16; p++) sendA(p);
    drainA("backpressure", start, 4);

    $display("[TB] back-to-back frames");
    start = aGot;
    aSumQ = '{54, 63, 90, 99, 954, 963, 990, 999};
    for (int p = 1; p <= 16; p++) sendA(p);
    for (int p = 101; p <= 116; p++) sendA(p);
    drainA("back-to-back", start, 8);

    $display("[TB] clear mid-frame");
    start = aGot;
    for (int p = 1; p <= 7; p++) sendA(p);
    applyStimulusA(1'b1, NBITS'(99), 1'b1, 1'b1, hs, r, o);
    aSumQ = '{54, 63, 90, 99};
    for (int p = 1; p <= 16; p++) sendA(p);
    drainA("clear", start, 4);

    $display("[TB] async reset");
    aSumQ = '{54, 63, 90, 99};
    for (int p = 1; p <= 11; p++) sendA(p);
    applyStimulusA(1'b0, '0, 1'b0, 1'b0, hs, r, o);
    checkOutput("pre-reset out_valid", 128'(aOutValid), 128'(1));
    #2 reset_n = 1'b0;
    #1;
    checkOutput("async reset out_valid", 128'(aOutValid), 128'(0));
    checkOutput("async reset in_ready", 128'(aInReady), 128'(1));
    #5 reset_n = 1'b1;
    aQ.delete();
    aRow = 0; aCol = 0;
    aSumQ = '{54, 63, 90, 99};
    start = aGot;
    for (int p = 1; p <= 16; p++) sendA(p);
    drainA("after reset", start, 4);

    $display("[TB] random stall 8x6");
    start = bGot;
    bSent = 0; n = 0;
    while (bSent < BW*BH && n < 3000) begin
      applyStimulusB($urandom_range(0, 3) != 0, NBITS'($urandom), $urandom_range(0, 3) != 0, hs);
      if (hs) bSent++;
      n++;
    end
    checkOutput("random pixels sent", 128'(bSent), 128'(BW*BH));
    n = 0;
    while ((bQ.size() > 0 || bOutValid) && n < 40) begin
      applyStimulusB(1'b0, '0, 1'b1, hs);
      n++;
    end
    checkOutput("random window count", 128'(bGot - start), 128'(24));
    checkOutput("random queue empty", 128'(bQ.size()), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
